// File: rtl/oloca_pkg.sv
// oloca_pkg
// Shared definitions for the OLOCA approximate accumulator:
//   - default parameter values
//   - accumulator state encoding (IDLE / ACCUM)
//   - clamp_k: limits a run-time imprecise-width request to the legal range
package oloca_pkg;

  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_ACC_WIDTH     = 32;
  localparam int DEF_MAX_IMPRECISE = 16;
  localparam int DEF_CNT_WIDTH     = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Requests above the largest legal imprecise width saturate to it.
  function automatic int clamp_k(input int sel, input int max_k);
    return (sel > max_k) ? max_k : sel;
  endfunction

endpackage

// File: rtl/oloca_var_adder.sv
// oloca_var_adder
// Combinational OLOCA-style approximate adder with a run-time imprecise width.
//   a, b : WIDTH-bit unsigned operands
//   k    : imprecise width request (clamped to MAX_IMPRECISE internally)
//   sum  : WIDTH-bit approximate sum
//   ovf  : carry out of the top bit
// For k > 0 the low k bits are not added:
//   bits below k-2 are forced to one, bits k-2 and k-1 are a|b, and the carry
//   into bit k is a[k-1]|b[k-1]. Bits k and up form an exact ripple adder.
// k = 0 degenerates to a plain exact adder.
module oloca_var_adder
  import oloca_pkg::*;
#(
  parameter int WIDTH         = DEF_ACC_WIDTH,
  parameter int MAX_IMPRECISE = DEF_MAX_IMPRECISE,
  parameter int KW            = $clog2(MAX_IMPRECISE + 1)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  int   k_eff;
  logic carry;

  always_comb begin
    k_eff = clamp_k(int'(k), MAX_IMPRECISE);
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < k_eff) begin
        // Imprecise region: only the top two bits look at the operands.
        if (i + 2 < k_eff) begin
          sum[i] = 1'b1;
        end else begin
          sum[i] = a[i] | b[i];
        end
        carry = (i == k_eff - 1) ? (a[i] | b[i]) : 1'b0;
      end else begin
        sum[i] = a[i] ^ b[i] ^ carry;
        carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
    end
    ovf = carry;
  end

endmodule

// File: rtl/oloca_accumulator.sv
// oloca_accumulator
// Streaming approximate accumulator: sums groups of unsigned beats framed by
// in_first / in_last, one beat per clock, saturating on overflow.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   imp_sel              imprecise width k, sampled on a group's opening beat
//   in_valid/in_ready    input beat handshake
//   in_data              input operand (zero-extended to ACC_WIDTH)
//   in_first/in_last     group framing
//   out_valid/out_ready  result handshake
//   out_data             group sum (saturated to all ones)
//   out_sat              group saturated at least once
//   out_count            beats in group (saturating)
// Handshake: a transfer happens on a rising edge where valid && ready. A held
// result (out_valid && !out_ready) stalls every input beat; a new result may
// be loaded on the same edge the old one is accepted.
module oloca_accumulator
  import oloca_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH     = DEF_ACC_WIDTH,
  parameter int MAX_IMPRECISE = DEF_MAX_IMPRECISE,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter int SEL_WIDTH     = $clog2(MAX_IMPRECISE + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEL_WIDTH-1:0]  imp_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_sat,
  output logic [CNT_WIDTH-1:0]  out_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [SEL_WIDTH-1:0]   k_q, k_d;
  logic                   out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   out_sat_q, out_sat_d;
  logic [CNT_WIDTH-1:0]   out_count_q, out_count_d;

  logic                   accept;
  logic                   open_beat;
  logic [ACC_WIDTH-1:0]   add_a, add_b, add_sum, result;
  logic [SEL_WIDTH-1:0]   add_k;
  logic                   add_ovf;
  logic                   sticky_base;
  logic [CNT_WIDTH-1:0]   cnt_upd;

  assign in_ready  = rst_n & ~(out_valid_q & ~out_ready);
  assign accept    = in_valid & in_ready;
  assign open_beat = in_first | (state_q == IDLE);

  // An opening beat goes through the adder as an exact 0 + in_data, so a
  // group always starts from the exact operand value.
  assign add_a = open_beat ? '0 : acc_q;
  assign add_b = ACC_WIDTH'(in_data);
  assign add_k = open_beat ? '0 : k_q;

  oloca_var_adder #(
    .WIDTH         (ACC_WIDTH),
    .MAX_IMPRECISE (MAX_IMPRECISE),
    .KW            (SEL_WIDTH)
  ) u_adder (
    .a   (add_a),
    .b   (add_b),
    .k   (add_k),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign result      = add_ovf ? '1 : add_sum;
  assign sticky_base = open_beat ? 1'b0 : sticky_q;
  assign cnt_upd     = open_beat ? CNT_WIDTH'(1)
                     : ((cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_count_d = out_count_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (open_beat) begin
        k_d = SEL_WIDTH'(clamp_k(int'(imp_sel), MAX_IMPRECISE));
      end
      if (in_last) begin
        out_valid_d = 1'b1;
        out_data_d  = result;
        out_sat_d   = sticky_base | add_ovf;
        out_count_d = cnt_upd;
        acc_d       = '0;
        sticky_d    = 1'b0;
        cnt_d       = '0;
        state_d     = IDLE;
      end else begin
        acc_d    = result;
        sticky_d = sticky_base | add_ovf;
        cnt_d    = cnt_upd;
        state_d  = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_oloca_accumulator.sv
// tb_oloca_accumulator
// Self-checking bench for oloca_accumulator with ACC_WIDTH=20: directed
// vector table, hand-written backpressure / reset / count sequences, and a
// randomized run against an arithmetic reference model.
module tb_oloca_accumulator;

  localparam int DW = 16;
  localparam int AW = 20;
  localparam int MK = 16;
  localparam int CW = 8;
  localparam int SW = 5;
  localparam longint MAXV = (64'd1 << AW) - 1;
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] imp_sel = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_first = 1'b0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_data;
  logic          out_sat;
  logic [CW-1:0] out_count;

  always #5 clk = ~clk;

  oloca_accumulator #(
    .DATA_WIDTH    (DW),
    .ACC_WIDTH     (AW),
    .MAX_IMPRECISE (MK),
    .CNT_WIDTH     (CW),
    .SEL_WIDTH     (SW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imp_sel   (imp_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_count (out_count)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  // Expected results in delivery order: {sat, count, data}.
  logic [AW+CW:0] exp_q[$];

  bit     m_in_group;
  longint m_acc;
  bit     m_sticky;
  int     m_cnt;
  int     m_k;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Approximate sum from the arithmetic definition: the upper part (bits k
  // and up) is an ordinary sum plus an OR-carry, the lower k bits are a
  // pattern of ones with the top two bits OR-ed. Returns the unsaturated sum.
  function automatic longint ref_add(input longint a, input longint b, input int k);
    longint orv, hi, lo;
    if (k == 0) return a + b;
    orv = a | b;
    hi  = (a >> k) + (b >> k) + ((orv >> (k - 1)) & 64'd1);
    if (k == 1) lo = orv & 64'd1;
    else        lo = (orv & (64'd3 << (k - 2))) | ((64'd1 << (k - 2)) - 1);
    return (hi << k) | lo;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_in_group = 0;
    m_acc      = 0;
    m_sticky   = 0;
    m_cnt      = 0;
    m_k        = 0;
  endtask

  task automatic model_beat(input logic [DW-1:0] d, input bit f, input bit l, input int sel);
    bit     opn, st, ovf;
    longint tot, res;
    opn = f || !m_in_group;
    if (opn) begin
      tot   = longint'(d);
      m_k   = (sel > MK) ? MK : sel;
      st    = 0;
      m_cnt = 1;
    end else begin
      tot   = ref_add(m_acc, longint'(d), m_k);
      st    = m_sticky;
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end
    ovf = (tot > MAXV);
    res = ovf ? MAXV : tot;
    st  = st | ovf;
    if (l) begin
      exp_q.push_back({st, m_cnt[CW-1:0], res[AW-1:0]});
      m_in_group = 0;
      m_acc      = 0;
      m_sticky   = 0;
      m_cnt      = 0;
    end else begin
      m_in_group = 1;
      m_acc      = res;
      m_sticky   = st;
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; ends at the next falling edge.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit f, input bit l,
                      input int sel, input bit r);
    logic [AW+CW:0] e;
    bit exp_rdy, acc;
    in_valid  = v;
    in_data   = d;
    in_first  = f;
    in_last   = l;
    imp_sel   = SW'(sel);
    out_ready = r;
    #1;
    exp_rdy = !(exp_q.size() > 0 && !r);
    check("in_ready", longint'(in_ready), longint'(exp_rdy));
    check("out_valid", longint'(out_valid), longint'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      check("out_data", longint'(out_data), longint'(e[AW-1:0]));
      check("out_count", longint'(out_count), longint'(e[AW+CW-1:AW]));
      check("out_sat", longint'(out_sat), longint'(e[AW+CW]));
      if (r) void'(exp_q.pop_front());
    end
    acc = v && exp_rdy;
    @(posedge clk);
    if (acc) model_beat(d, f, l, sel);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [DW-1:0] data;
    bit            first;
    bit            last;
    int            sel;
    bit            chk;
    logic [AW-1:0] exp_data;
    bit            exp_sat;
    int            exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [DW-1:0] d, input bit f, input bit l, input int sel,
                         input bit c, input logic [AW-1:0] ed, input bit es, input int ec);
    vec_t v;
    v.data = d; v.first = f; v.last = l; v.sel = sel;
    v.chk = c; v.exp_data = ed; v.exp_sat = es; v.exp_cnt = ec;
    vecs.push_back(v);
  endtask

  initial begin
    model_reset();

    // exact mode
    add_vec(16'h000F, 1, 0, 0, 0, 0, 0, 0);
    add_vec(16'h0001, 0, 1, 0, 1, 20'h00010, 0, 2);
    // approximate k=4: OR-carry into bit 4, low bits forced/OR-ed
    add_vec(16'h000F, 1, 0, 4, 0, 0, 0, 0);
    add_vec(16'h0001, 0, 1, 4, 1, 20'h0001F, 0, 2);
    // saturation: 17 x 0xFFFF exceeds 20 bits on the 17th beat
    for (int i = 0; i < 17; i++)
      add_vec(16'hFFFF, i == 0, i == 16, 0, i == 16, 20'hFFFFF, 1, 17);
    add_vec(16'h0002, 1, 1, 0, 1, 20'h00002, 0, 1);
    // k latched at open (4); mid-group imp_sel=0 is ignored
    add_vec(16'h000F, 1, 0, 4, 0, 0, 0, 0);
    add_vec(16'h0001, 0, 0, 0, 0, 0, 0, 0);
    add_vec(16'h0001, 0, 1, 0, 1, 20'h0002F, 0, 3);
    // mid-group restart with exact mode: only 0x7 + 0x9 survive
    add_vec(16'h0100, 1, 0, 4, 0, 0, 0, 0);
    add_vec(16'h0003, 0, 0, 4, 0, 0, 0, 0);
    add_vec(16'h0007, 1, 0, 0, 0, 0, 0, 0);
    add_vec(16'h0009, 0, 1, 0, 1, 20'h00010, 0, 2);
    // imp_sel above MAX_IMPRECISE clamps to 16
    add_vec(16'h0001, 1, 0, 31, 0, 0, 0, 0);
    add_vec(16'h0002, 0, 1, 31, 1, 20'h03FFF, 0, 2);
    // k=1 and k=2 edge widths
    add_vec(16'h0003, 1, 0, 1, 0, 0, 0, 0);
    add_vec(16'h0001, 0, 1, 1, 1, 20'h00005, 0, 2);
    add_vec(16'h0002, 1, 0, 2, 0, 0, 0, 0);
    add_vec(16'h0002, 0, 1, 2, 1, 20'h00006, 0, 2);

    // reset values (rst_n low from time 0)
    #3;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_sat", longint'(out_sat), 0);
    check("rst_out_count", longint'(out_count), 0);
    check("rst_in_ready", longint'(in_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // table
    foreach (vecs[i]) begin
      step(1, vecs[i].data, vecs[i].first, vecs[i].last, vecs[i].sel, 1);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_valid", i), longint'(out_valid), 1);
        check($sformatf("vec%0d_data", i), longint'(out_data), longint'(vecs[i].exp_data));
        check($sformatf("vec%0d_sat", i), longint'(out_sat), longint'(vecs[i].exp_sat));
        check($sformatf("vec%0d_count", i), longint'(out_count), longint'(vecs[i].exp_cnt));
      end
    end
    idle(1);

    // backpressure: stalled result blocks input, stays stable, then drains
    // on the same edge a new one-beat group loads
    step(1, 16'h0010, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 16'h0033, 1, 1, 0, 0);
      check("bp_held_data", longint'(out_data), 'h10);
      check("bp_held_valid", longint'(out_valid), 1);
    end
    step(1, 16'h0005, 1, 1, 0, 1);
    check("bp_new_valid", longint'(out_valid), 1);
    check("bp_new_data", longint'(out_data), 'h5);
    check("bp_new_count", longint'(out_count), 1);
    idle(1);
    check("bp_drained", longint'(out_valid), 0);

    // beat counter saturates at 2^CW-1
    for (int i = 0; i < CNT_MAX + 5; i++)
      step(1, 16'h0000, i == 0, i == CNT_MAX + 4, 0, 1);
    check("cnt_sat_count", longint'(out_count), CNT_MAX);
    check("cnt_sat_data", longint'(out_data), 0);
    idle(1);

    // reset mid-group: outputs clear at once, then a fresh group works
    step(1, 16'h0011, 1, 1, 0, 1);
    idle(1);
    for (int i = 0; i < 3; i++) step(1, 16'h0100, i == 0, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", longint'(out_valid), 0);
    check("mrst_out_data", longint'(out_data), 0);
    check("mrst_out_sat", longint'(out_sat), 0);
    check("mrst_out_count", longint'(out_count), 0);
    check("mrst_in_ready", longint'(in_ready), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 16'h0007, 1, 1, 0, 1);
    check("mrst_new_data", longint'(out_data), 'h7);
    check("mrst_new_count", longint'(out_count), 1);
    check("mrst_new_valid", longint'(out_valid), 1);
    idle(1);

    // randomized traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      logic [DW-1:0] d;
      d = DW'($urandom);
      if ($urandom_range(0, 2) == 0) d = 16'hFFF0 | {12'h000, d[3:0]};
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 9) == 0,
           $urandom_range(0, 5) == 0, int'($urandom_range(0, 31)),
           $urandom_range(0, 3) != 0);
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
